thumb_decode_stage: RTL and testbench

Pipelined Thumb-1 instruction decode stage; the parametrised successor of the current single-register decoder. Accepts 16-bit halfwords from fetch over a valid/ready handshake and emits one registered, fully decoded micro-op per instruction to execute. Adds backpressure, flush, scaled immediates, a destination-register field, illegal-opcode flagging and two-halfword BL reassembly.

---
 rtl/decode_pkg.sv | 24 ++
 rtl/thumb_field_decode.sv | 73 +++++++
 rtl/thumb_decode_stage.sv | 112 +++++++++++
 tb/tb_thumb_decode_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared types and constants for the Thumb decode stage
package decode_pkg;

    typedef enum logic [3:0] {
        NOP,
        ADD_IMM3,
        SUB_SP,
        MOV_IMM,
        MOV_REG,
        LDR_IMM,
        STR_IMM,
        B,
        BCOND,
        CMP_IMM,
        BL,
        ILLEGAL
    } op_e;

    localparam int REG_SP = 13;
    localparam int REG_LR = 14;
    localparam int REG_PC = 15;
    localparam logic [3:0] COND_AL = 4'hE;

endpackage

// File: rtl/thumb_field_decode.sv
// rtl/thumb_field_decode.sv - combinational single-halfword Thumb field decoder
module thumb_field_decode
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic [15:0]       ir,
    output op_e               op,
    output logic [REG_AW-1:0] rn,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] rd,
    output logic [3:0]        cond,
    output logic [DATA_W-1:0] imm,
    output logic              bl_prefix,
    output logic              bl_suffix
);

    // BL halves decode as ILLEGAL here; the top overrides them with its FSM.
    always_comb begin
        op        = ILLEGAL;
        rn        = '0;
        rt        = '0;
        rd        = '0;
        cond      = COND_AL;
        imm       = '0;
        bl_prefix = (ir[15:11] == 5'b11110);
        bl_suffix = (ir[15:11] == 5'b11111);
        if (ir[15:9] == 7'b0001110) begin
            op  = ADD_IMM3;
            rn  = REG_AW'(ir[5:3]);
            rd  = REG_AW'(ir[2:0]);
            imm = DATA_W'(ir[8:6]);
        end else if (ir[15:7] == 9'b101100001) begin
            op  = SUB_SP;
            rn  = REG_AW'(REG_SP);
            rd  = REG_AW'(REG_SP);
            imm = DATA_W'({ir[6:0], 2'b00});
        end else if (ir[15:11] == 5'b00100) begin
            op  = MOV_IMM;
            rd  = REG_AW'(ir[10:8]);
            imm = DATA_W'(ir[7:0]);
        end else if (ir[15:8] == 8'b01000110) begin
            op  = MOV_REG;
            rn  = REG_AW'(ir[6:3]);
            rd  = REG_AW'({ir[7], ir[2:0]});
        end else if (ir[15:11] == 5'b01101) begin
            op  = LDR_IMM;
            rn  = REG_AW'(ir[5:3]);
            rd  = REG_AW'(ir[2:0]);
            imm = DATA_W'({ir[10:6], 2'b00});
        end else if (ir[15:11] == 5'b01100) begin
            op  = STR_IMM;
            rn  = REG_AW'(ir[5:3]);
            rt  = REG_AW'(ir[2:0]);
            imm = DATA_W'({ir[10:6], 2'b00});
        end else if (ir[15:11] == 5'b11100) begin
            op  = B;
            rn  = REG_AW'(REG_PC);
            imm = DATA_W'($signed({ir[10:0], 1'b0}));
        end else if (ir[15:12] == 4'b1101 && ir[11:9] != 3'b111) begin
            op   = BCOND;
            rn   = REG_AW'(REG_PC);
            cond = ir[11:8];
            imm  = DATA_W'($signed({ir[7:0], 1'b0}));
        end else if (ir[15:11] == 5'b00101) begin
            op  = CMP_IMM;
            rn  = REG_AW'(ir[10:8]);
            imm = DATA_W'(ir[7:0]);
        end
    end

endmodule

// File: rtl/thumb_decode_stage.sv
// rtl/thumb_decode_stage.sv - registered Thumb-1 decode stage with BL pairing
module thumb_decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [15:0]       i_ir,
    output logic              o_ready,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output op_e               o_op,
    output logic [REG_AW-1:0] o_rn,
    output logic [REG_AW-1:0] o_rt,
    output logic [REG_AW-1:0] o_rd,
    output logic [3:0]        o_cond,
    output logic [DATA_W-1:0] o_imm,
    output logic              o_illegal
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BL_HI = 1'b1;

    logic [0:0]        state;
    logic [10:0]       prefix;
    logic              accept;

    op_e               f_op;
    logic [REG_AW-1:0] f_rn, f_rt, f_rd;
    logic [3:0]        f_cond;
    logic [DATA_W-1:0] f_imm;
    logic              f_prefix, f_suffix;

    op_e               n_op;
    logic [REG_AW-1:0] n_rn, n_rt, n_rd;
    logic [3:0]        n_cond;
    logic [DATA_W-1:0] n_imm;

    thumb_field_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fields (
        .ir        (i_ir),
        .op        (f_op),
        .rn        (f_rn),
        .rt        (f_rt),
        .rd        (f_rd),
        .cond      (f_cond),
        .imm       (f_imm),
        .bl_prefix (f_prefix),
        .bl_suffix (f_suffix)
    );

    assign o_ready = !o_valid || i_ready;
    assign accept  = i_valid && o_ready;

    // While a prefix is pending, only a suffix completes BL; anything else is ILLEGAL.
    always_comb begin
        n_op   = f_op;
        n_rn   = f_rn;
        n_rt   = f_rt;
        n_rd   = f_rd;
        n_cond = f_cond;
        n_imm  = f_imm;
        if (state == ST_BL_HI) begin
            n_op   = f_suffix ? BL : ILLEGAL;
            n_rn   = f_suffix ? REG_AW'(REG_PC) : '0;
            n_rt   = '0;
            n_rd   = f_suffix ? REG_AW'(REG_LR) : '0;
            n_cond = COND_AL;
            n_imm  = f_suffix ? DATA_W'($signed({prefix, i_ir[10:0], 1'b0})) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            prefix    <= '0;
            o_valid   <= 1'b0;
            o_op      <= NOP;
            o_rn      <= '0;
            o_rt      <= '0;
            o_rd      <= '0;
            o_cond    <= COND_AL;
            o_imm     <= '0;
            o_illegal <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
            state   <= ST_IDLE;
        end else if (accept) begin
            if (state == ST_IDLE && f_prefix) begin
                prefix  <= i_ir[10:0];
                state   <= ST_BL_HI;
                o_valid <= 1'b0;
            end else begin
                state     <= ST_IDLE;
                o_valid   <= 1'b1;
                o_op      <= n_op;
                o_rn      <= n_rn;
                o_rt      <= n_rt;
                o_rd      <= n_rd;
                o_cond    <= n_cond;
                o_imm     <= n_imm;
                o_illegal <= (n_op == ILLEGAL);
            end
        end else if (o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_thumb_decode_stage.sv
// tb/tb_thumb_decode_stage.sv - scoreboard bench for thumb_decode_stage
module tb_thumb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [15:0] i_ir = '0;
    logic        o_ready;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    op_e         o_op;
    logic [3:0]  o_rn, o_rt, o_rd, o_cond;
    logic [31:0] o_imm;
    logic        o_illegal;

    thumb_decode_stage #(.DATA_W(32), .REG_AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ir      (i_ir),
        .o_ready   (o_ready),
        .i_flush   (i_flush),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_op      (o_op),
        .o_rn      (o_rn),
        .o_rt      (o_rt),
        .o_rd      (o_rd),
        .o_cond    (o_cond),
        .o_imm     (o_imm),
        .o_illegal (o_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;
        int          rn;
        int          rt;
        int          rd;
        int          cond;
        logic [31:0] imm;
        int          ill;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   bl_pend = 0;
    int   bl_hi = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
        end
    endfunction

    function automatic exp_t mk(input op_e op, input int rn, input int rt, input int rd,
                                input int cond, input int imm);
        exp_t e;
        e.op   = int'(op);
        e.rn   = rn;
        e.rt   = rt;
        e.rd   = rd;
        e.cond = cond;
        e.imm  = 32'(imm);
        e.ill  = (op == ILLEGAL) ? 1 : 0;
        return e;
    endfunction

    function automatic int sext(input int v, input int bits);
        int half = 1 << (bits - 1);
        return (v >= half) ? v - 2 * half : v;
    endfunction

    // Reference decode of a single (non-BL) halfword, from the instruction table.
    function automatic exp_t ref_decode(input int h);
        int top5 = h >> 11;
        if ((h >> 9) == 14)
            return mk(ADD_IMM3, (h >> 3) % 8, 0, h % 8, 14, (h >> 6) % 8);
        if ((h >> 7) == 353)
            return mk(SUB_SP, 13, 0, 13, 14, (h % 128) * 4);
        if (top5 == 4)
            return mk(MOV_IMM, 0, 0, (h >> 8) % 8, 14, h % 256);
        if ((h >> 8) == 70)
            return mk(MOV_REG, (h >> 3) % 16, 0, ((h >> 7) % 2) * 8 + h % 8, 14, 0);
        if (top5 == 13)
            return mk(LDR_IMM, (h >> 3) % 8, 0, h % 8, 14, ((h >> 6) % 32) * 4);
        if (top5 == 12)
            return mk(STR_IMM, (h >> 3) % 8, h % 8, 0, 14, ((h >> 6) % 32) * 4);
        if (top5 == 28)
            return mk(B, 15, 0, 0, 14, sext(h % 2048, 11) * 2);
        if ((h >> 12) == 13 && ((h >> 8) % 16) < 14)
            return mk(BCOND, 15, 0, 0, (h >> 8) % 16, sext(h % 256, 8) * 2);
        if (top5 == 5)
            return mk(CMP_IMM, (h >> 8) % 8, 0, 0, 14, h % 256);
        return mk(ILLEGAL, 0, 0, 0, 14, 0);
    endfunction

    function automatic void model_accept(input int h);
        int top5 = h >> 11;
        if (bl_pend) begin
            bl_pend = 0;
            if (top5 == 31)
                sb.push_back(mk(BL, 15, 0, 14, 14, sext(bl_hi * 2048 + h % 2048, 22) * 2));
            else
                sb.push_back(mk(ILLEGAL, 0, 0, 0, 14, 0));
        end else if (top5 == 30) begin
            bl_pend = 1;
            bl_hi   = h % 2048;
        end else begin
            sb.push_back(ref_decode(h));
        end
    endfunction

    task automatic step(input bit v, input logic [15:0] ir, input bit rdy, input bit fl);
        @(negedge clk);
        i_valid = v;
        i_ir    = ir;
        i_ready = rdy;
        i_flush = fl;
        #2;
        if (rst) begin
            sb.delete();
            bl_pend = 0;
        end else if (fl) begin
            sb.delete();
            bl_pend = 0;
        end else if (v && o_ready) begin
            model_accept(int'(ir));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 16'h0, 1, 0);
        step(0, 16'h0, 1, 0);
        @(negedge clk);
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_op", 32'(o_op), 32'(NOP));
        chk("rst_regs", {20'd0, o_rn, o_rt, o_rd}, 32'd0);
        chk("rst_cond", 32'(o_cond), 32'hE);
        chk("rst_imm", o_imm, 32'd0);
        chk("rst_illegal", 32'(o_illegal), 32'd0);
        rst = 1'b0;
    endtask

    // Monitor: checks o_ready and compares any presented op against the queue head.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            chk("o_ready", 32'(o_ready), 32'(!o_valid || i_ready));
            if (o_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_op", 32'(o_op), 32'hFFFF_FFFF);
                end else begin
                    chk("op", 32'(o_op), 32'(sb[0].op));
                    chk("rn", 32'(o_rn), 32'(sb[0].rn));
                    chk("rt", 32'(o_rt), 32'(sb[0].rt));
                    chk("rd", 32'(o_rd), 32'(sb[0].rd));
                    chk("cond", 32'(o_cond), 32'(sb[0].cond));
                    chk("imm", o_imm, sb[0].imm);
                    chk("illegal", 32'(o_illegal), 32'(sb[0].ill));
                    if (i_ready && !i_flush) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [15:0] r;
        logic [10:0] lo;
        int sel;
        do_reset();

        step(1, 16'h1C8A, 1, 0);
        step(1, 16'hB082, 1, 0);
        step(1, 16'h6848, 1, 0);
        step(1, 16'hF7FF, 1, 0);
        step(1, 16'hFFFE, 1, 0);
        step(1, 16'hD1FE, 1, 0);
        step(1, 16'h2005, 0, 0);
        step(1, 16'h2005, 0, 0);
        step(1, 16'h2005, 0, 0);
        step(1, 16'h2005, 1, 0);
        step(1, 16'hF000, 1, 0);
        step(1, 16'hF800, 1, 1);
        step(1, 16'hF800, 1, 0);
        step(1, 16'hDE00, 1, 0);
        step(1, 16'hFFFF, 1, 0);
        step(1, 16'hF000, 1, 0);
        step(1, 16'h6048, 1, 0);
        step(1, 16'h46C7, 1, 0);
        step(1, 16'hE400, 1, 0);
        step(1, 16'h2DFF, 1, 0);
        step(1, 16'hF400, 1, 0);
        step(0, 16'h0, 1, 0);
        step(1, 16'hF801, 1, 0);
        step(1, 16'hF123, 1, 0);
        do_reset();
        step(1, 16'hF800, 1, 0);
        step(0, 16'h0, 1, 0);

        for (int i = 0; i < 1500; i++) begin
            sel = int'($urandom_range(0, 9));
            r   = 16'($urandom);
            lo  = r[10:0];
            if (sel < 2)       r = {5'b11110, lo};
            else if (sel == 2) r = {5'b11111, lo};
            else if (sel == 3) r = {4'b1101, r[11:0]};
            step($urandom_range(0, 9) < 8, r, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 39) == 0);
        end

        for (int i = 0; i < 4; i++) step(0, 16'h0, 1, 0);
        chk("drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
